// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clkdiv_sel clock-enable generator.
// Define CLKDIV_SEL_DIV8_EN to enable the /8 code and a full 3-bit period counter.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [1:0] DIV1 = 2'd0;
    localparam logic [1:0] DIV2 = 2'd1;
    localparam logic [1:0] DIV4 = 2'd2;
    localparam logic [1:0] DIV8 = 2'd3;

`ifdef CLKDIV_SEL_DIV8_EN
    localparam int CNT_W = 3;
`else
    localparam int CNT_W = 2;
`endif

    // Last count value of a period, i.e. N-1 for N = 1 << code.
    function automatic logic [2:0] div_len(input logic [1:0] code);
        case (code)
            DIV1:    return 3'd0;
            DIV2:    return 3'd1;
            DIV4:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/clkdiv_sel_cnt.sv
// Period counter with registered tick/phase decode for clkdiv_sel.
// Counter width follows CLKDIV_SEL_DIV8_EN through clkdiv_pkg::CNT_W.
module clkdiv_sel_cnt
    import clkdiv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] div,
    input  logic [1:0] div_nxt,
    output logic       wrap,
    output logic       tick,
    output logic       phase
);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       cnt_ext;
    logic [2:0]       cnt_nxt;
    logic [2:0]       len_nxt;

    assign cnt_ext = 3'(cnt);
    assign wrap    = (cnt_ext == div_len(div));
    assign len_nxt = div_len(div_nxt);

    always_comb begin
        cnt_nxt = cnt_ext;
        if (clr) begin
            cnt_nxt = 3'd0;
        end else if (en) begin
            cnt_nxt = wrap ? 3'd0 : cnt_ext + 3'd1;
        end
    end

    // tick/phase are decoded from the next count and next divide so they
    // line up with the registered count in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            tick  <= 1'b0;
            phase <= 1'b0;
        end else begin
            cnt   <= cnt_nxt[CNT_W-1:0];
            tick  <= !clr && (cnt_nxt == len_nxt);
            phase <= !clr && (cnt_nxt > (len_nxt >> 1));
        end
    end

endmodule

// File: rtl/clkdiv_sel.sv
// Runtime-selectable clock-enable generator: /1,/2,/4 (and /8 with
// CLKDIV_SEL_DIV8_EN) with ratio changes and stops applied only at period wraps.
module clkdiv_sel
    import clkdiv_pkg::*;
#(
    parameter logic [1:0] RESET_DIV = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       sel_valid,
    input  logic [1:0] sel_div,
    output logic       sel_ready,
    output logic       tick,
    output logic       phase,
    output logic [1:0] cur_div,
    output logic       busy,
    output logic       err
);

`ifdef CLKDIV_SEL_DIV8_EN
    localparam logic [1:0] RST_DIV = RESET_DIV;
`else
    localparam logic [1:0] RST_DIV = (RESET_DIV == DIV8) ? DIV4 : RESET_DIV;
`endif

    state_t     state, state_nxt;
    logic [1:0] cur_div_nxt;
    logic [1:0] pend_div, pend_div_nxt;
    logic       accept;
    logic       code_ok;
    logic       wrap;

    assign accept = sel_valid && sel_ready;

`ifdef CLKDIV_SEL_DIV8_EN
    assign code_ok = 1'b1;
`else
    assign code_ok = (sel_div != DIV8);
`endif

    always_comb begin
        state_nxt    = state;
        cur_div_nxt  = cur_div;
        pend_div_nxt = pend_div;
        case (state)
            IDLE: begin
                if (accept && code_ok) begin
                    cur_div_nxt = sel_div;
                end
                if (run) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A real ratio change outranks a simultaneous stop request.
                if (accept && code_ok && (sel_div != cur_div)) begin
                    pend_div_nxt = sel_div;
                    state_nxt    = SWITCH;
                end else if (!run) begin
                    state_nxt = STOP;
                end
            end
            SWITCH: begin
                if (wrap) begin
                    cur_div_nxt = pend_div;
                    state_nxt   = run ? RUN : IDLE;
                end
            end
            STOP: begin
                if (run) begin
                    state_nxt = RUN;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_div   <= RST_DIV;
            pend_div  <= RST_DIV;
            sel_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_div   <= cur_div_nxt;
            pend_div  <= pend_div_nxt;
            sel_ready <= (state_nxt == IDLE) || (state_nxt == RUN);
            busy      <= (state_nxt != IDLE);
            err       <= accept && !code_ok;
        end
    end

    clkdiv_sel_cnt u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_nxt == IDLE),
        .en      (state != IDLE),
        .div     (cur_div),
        .div_nxt (cur_div_nxt),
        .wrap    (wrap),
        .tick    (tick),
        .phase   (phase)
    );

endmodule

// File: tb/tb_clkdiv_sel.sv
// Table-driven bench for clkdiv_sel with a queue scoreboard of expected outputs.
module tb_clkdiv_sel;

    typedef struct packed {
        logic       tick;
        logic       phase;
        logic       ready;
        logic       busy;
        logic       err;
        logic [1:0] cur;
    } exp_t;

    typedef struct packed {
        logic       run;
        logic       sv;
        logic [1:0] sd;
        exp_t       e;
    } vec_t;

`ifdef CLKDIV_SEL_DIV8_EN
    localparam logic [1:0] CLAMP_EXP = 2'd3;
`else
    localparam logic [1:0] CLAMP_EXP = 2'd2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       sel_valid;
    logic [1:0] sel_div;
    logic       sel_ready, tick, phase, busy, err;
    logic [1:0] cur_div;
    logic       c_ready, c_tick, c_phase, c_busy, c_err;
    logic [1:0] c_div;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t tbl[$];

    clkdiv_sel #(.RESET_DIV(2'd2)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .sel_valid (sel_valid),
        .sel_div   (sel_div),
        .sel_ready (sel_ready),
        .tick      (tick),
        .phase     (phase),
        .cur_div   (cur_div),
        .busy      (busy),
        .err       (err)
    );

    clkdiv_sel #(.RESET_DIV(2'd3)) dut_clamp (
        .clk       (clk),
        .rst       (rst),
        .run       (1'b0),
        .sel_valid (1'b0),
        .sel_div   (2'd0),
        .sel_ready (c_ready),
        .tick      (c_tick),
        .phase     (c_phase),
        .cur_div   (c_div),
        .busy      (c_busy),
        .err       (c_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(logic t, logic p, logic rd, logic b, logic e, logic [1:0] c);
        exp_t r;
        r.tick = t; r.phase = p; r.ready = rd; r.busy = b; r.err = e; r.cur = c;
        return r;
    endfunction

    function automatic vec_t mk(logic r, logic v, logic [1:0] d,
                                logic t, logic p, logic rd, logic b, logic e, logic [1:0] c);
        vec_t x;
        x.run = r; x.sv = v; x.sd = d; x.e = ex(t, p, rd, b, e, c);
        return x;
    endfunction

    function automatic exp_t outs();
        return exp_t'({tick, phase, sel_ready, busy, err, cur_div});
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got tick/phase/ready/busy/err/cur=%b want=%b", name, act, want);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] d,
                        input exp_t e, input string name);
        run       = r;
        sel_valid = v;
        sel_div   = d;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check(name, outs(), sb.pop_front());
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; sel_valid = 1'b0; sel_div = 2'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset", outs(), ex(0, 0, 0, 0, 0, 2'd2));
        check("reset_clamp", exp_t'({c_tick, c_phase, c_ready, c_busy, c_err, c_div}),
              ex(0, 0, 0, 0, 0, CLAMP_EXP));
        rst = 1'b0;

        // run sel d | tick phase ready busy err cur
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,2));  // first edge: ready rises
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,2));  // start /4
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,2));
        tbl.push_back(mk(1,0,0, 0,1,1,1,0,2));
        tbl.push_back(mk(1,0,0, 1,1,1,1,0,2));  // tick on cycle 4
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,2));
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,2));
        tbl.push_back(mk(1,0,0, 0,1,1,1,0,2));
        tbl.push_back(mk(1,0,0, 1,1,1,1,0,2));  // tick on cycle 8
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,2));
        tbl.push_back(mk(1,1,1, 0,0,0,1,0,2));  // request /2 mid-period
        tbl.push_back(mk(1,0,0, 0,1,0,1,0,2));
        tbl.push_back(mk(1,0,0, 1,1,0,1,0,2));
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));  // applied at wrap
        tbl.push_back(mk(1,0,0, 1,1,1,1,0,1));
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));
        tbl.push_back(mk(1,0,0, 1,1,1,1,0,1));
        tbl.push_back(mk(1,1,0, 0,0,0,1,0,1));  // request /1 at wrap edge
        tbl.push_back(mk(1,0,0, 1,1,0,1,0,1));
        tbl.push_back(mk(1,0,0, 1,0,1,1,0,0));  // /1: tick constant
        tbl.push_back(mk(1,0,0, 1,0,1,1,0,0));
        tbl.push_back(mk(1,0,0, 1,0,1,1,0,0));
        tbl.push_back(mk(1,1,1, 1,0,0,1,0,0));  // request /2 from /1
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));
        tbl.push_back(mk(1,0,0, 1,1,1,1,0,1));
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));
        tbl.push_back(mk(1,1,1, 1,1,1,1,0,1));  // same code: no switch
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));
        tbl.push_back(mk(1,0,0, 1,1,1,1,0,1));
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));
        tbl.push_back(mk(0,0,0, 1,1,0,1,0,1));  // stop mid-period
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,1));  // idle at wrap
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));
        tbl.push_back(mk(0,0,0, 1,1,0,1,0,1));  // stop ...
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,1));  // ... resumed before wrap
        tbl.push_back(mk(1,0,0, 1,1,1,1,0,1));
        tbl.push_back(mk(0,0,0, 0,0,0,1,0,1));  // stop at wrap edge
        tbl.push_back(mk(0,0,0, 1,1,0,1,0,1));
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,1));
        tbl.push_back(mk(0,1,2, 0,0,1,0,0,2));  // idle request applies now
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,2));
        tbl.push_back(mk(1,0,0, 0,0,1,1,0,2));
        tbl.push_back(mk(0,1,1, 0,0,0,1,0,2));  // request + stop together
        tbl.push_back(mk(0,0,0, 0,1,0,1,0,2));
        tbl.push_back(mk(0,0,0, 1,1,0,1,0,2));
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,1));  // switch applied, then idle
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,1));

        foreach (tbl[i]) begin
            step(tbl[i].run, tbl[i].sv, tbl[i].sd, tbl[i].e, $sformatf("vec%0d", i));
        end

`ifdef CLKDIV_SEL_DIV8_EN
        step(0, 1, 2'd3, ex(0,0,1,0,0,2'd3), "div8_sel");
        step(0, 0, 2'd0, ex(0,0,1,0,0,2'd3), "div8_hold");
        for (int k = 0; k < 19; k++) begin
            step(1, 0, 2'd0, ex((k % 8) == 7, (k % 8) >= 4, 1, 1, 0, 2'd3),
                 $sformatf("div8_run%0d", k));
        end
        for (int c = 3; c < 8; c++) begin
            step(0, 0, 2'd0, ex(c == 7, c >= 4, 0, 1, 0, 2'd3), $sformatf("div8_stop%0d", c));
        end
        step(0, 0, 2'd0, ex(0,0,1,0,0,2'd3), "div8_idle");
`else
        step(0, 1, 2'd3, ex(0,0,1,0,1,2'd1), "code3_err");
        step(0, 0, 2'd0, ex(0,0,1,0,0,2'd1), "code3_clear");
`endif

        step(0, 1, 2'd2, ex(0,0,1,0,0,2'd2), "pre_rst_sel");
        step(1, 0, 2'd0, ex(0,0,1,1,0,2'd2), "pre_rst_run");
        step(1, 1, 2'd0, ex(0,0,0,1,0,2'd2), "pre_rst_switch");
        rst = 1'b1;
        #1;
        check("async_rst", outs(), ex(0,0,0,0,0,2'd2));
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 2'd0, ex(0,0,1,0,0,2'd2), "post_rst_idle");
        step(1, 0, 2'd0, ex(0,0,1,1,0,2'd2), "post_rst_c1");
        step(1, 0, 2'd0, ex(0,0,1,1,0,2'd2), "post_rst_c2");
        step(1, 0, 2'd0, ex(0,1,1,1,0,2'd2), "post_rst_c3");
        step(1, 0, 2'd0, ex(1,1,1,1,0,2'd2), "post_rst_c4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
